// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sad_pkg
//  Description : Shared state encoding and width helpers for the SAD engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package sad_pkg;

    // Engine control states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sad_state_t;

    // Result width: worst case N * (2^PIX_W - 1) plus one bit of margin.
    function automatic int sad_width(input int pix_w, input int n);
        return pix_w + $clog2(n) + 1;
    endfunction

    // Word address width, never narrower than one bit (W=1 corner).
    function automatic int addr_width(input int n, input int lanes);
        int w;
        w = n / lanes;
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage : sad_pkg
`default_nettype wire

// File: rtl/sad_if.sv
`default_nettype none
// ============================================================================
//  Module      : sad_if
//  Description : Control, memory-read and result bundle of the SAD engine.
//                master = search control / pixel buffers, slave = engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sad_if #(
    parameter int PIX_W = 8,
    parameter int N     = 256,
    parameter int LANES = 4
) ();
    localparam int ADDR_W = sad_pkg::addr_width(N, LANES);
    localparam int SAD_W  = sad_pkg::sad_width(PIX_W, N);

    logic                   go;
    logic                   abort;
    logic                   thresh_en;
    logic [SAD_W-1:0]       thresh;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [LANES*PIX_W-1:0] a_data;
    logic [LANES*PIX_W-1:0] b_data;
    logic                   busy;
    logic                   done;
    logic [SAD_W-1:0]       sad;
    logic                   early;

    modport master (
        output go, abort, thresh_en, thresh, a_data, b_data,
        input  rd_en, rd_addr, busy, done, sad, early
    );

    modport slave (
        input  go, abort, thresh_en, thresh, a_data, b_data,
        output rd_en, rd_addr, busy, done, sad, early
    );

endinterface : sad_if
`default_nettype wire

// File: rtl/sad_absdiff_tree.sv
`default_nettype none
// ============================================================================
//  Module      : sad_absdiff_tree
//  Description : Combinational per-lane |a-b| followed by a lane sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_absdiff_tree #(
    parameter  int PIX_W  = 8,
    parameter  int LANES  = 4,
    localparam int TREE_W = PIX_W + $clog2(LANES)
) (
    input  wire logic [LANES*PIX_W-1:0] i_a,
    input  wire logic [LANES*PIX_W-1:0] i_b,
    output logic      [TREE_W-1:0]      o_sum
);

    logic [PIX_W-1:0]  w_diff [LANES];
    logic [TREE_W-1:0] w_acc;

    // One unsigned absolute difference per lane; never exceeds PIX_W bits.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PIX_W-1:0] w_a;
        logic [PIX_W-1:0] w_b;
        assign w_a       = i_a[k*PIX_W +: PIX_W];
        assign w_b       = i_b[k*PIX_W +: PIX_W];
        assign w_diff[k] = (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
    end

    // Lane sum; TREE_W holds LANES * (2^PIX_W - 1) without overflow.
    always_comb begin
        w_acc = '0;
        for (int k = 0; k < LANES; k++) begin
            w_acc = w_acc + TREE_W'(w_diff[k]);
        end
    end

    assign o_sum = w_acc;

endmodule : sad_absdiff_tree
`default_nettype wire

// File: rtl/sad_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sad_engine
//  Description : Multi-lane sum of absolute differences over two N-pixel
//                blocks in synchronous-read memories, with abort and
//                optional early termination against a threshold.
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_engine
    import sad_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int N     = 256,
    parameter int LANES = 4
) (
    input wire logic clk,
    input wire logic rst,
    sad_if.slave     bus
);

    localparam int W      = N / LANES;
    localparam int ADDR_W = addr_width(N, LANES);
    localparam int SAD_W  = sad_width(PIX_W, N);
    localparam int TREE_W = PIX_W + $clog2(LANES);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(W - 1);

    sad_state_t         r_state;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_vld;      // rd_en delayed: memory data valid now
    logic [SAD_W-1:0]   r_sum;
    logic [SAD_W-1:0]   r_thr;
    logic               r_thr_en;
    logic               r_hit;
    logic               r_busy;
    logic               r_done;
    logic [SAD_W-1:0]   r_sad;
    logic               r_early;

    logic [TREE_W-1:0]  w_tree;
    logic [SAD_W-1:0]   w_sum_next;
    logic               w_hit;

    sad_absdiff_tree #(
        .PIX_W (PIX_W),
        .LANES (LANES)
    ) u_tree (
        .i_a   (bus.a_data),
        .i_b   (bus.b_data),
        .o_sum (w_tree)
    );

    assign w_sum_next = r_sum + SAD_W'(w_tree);
    // Compares the registered sum, so it lags issue by two cycles.
    assign w_hit      = r_thr_en && (r_sum >= r_thr);

    // Control FSM, address counter, accumulator and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rd_en  <= 1'b0;
            r_addr   <= '0;
            r_vld    <= 1'b0;
            r_sum    <= '0;
            r_thr    <= '0;
            r_thr_en <= 1'b0;
            r_hit    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sad    <= '0;
            r_early  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_vld  <= r_rd_en;
            if (r_vld) begin
                r_sum <= w_sum_next;
            end

            if (bus.abort && (r_state != IDLE)) begin
                // Drop the run; the in-flight word never reaches the result.
                r_state <= IDLE;
                r_rd_en <= 1'b0;
                r_vld   <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.go && !bus.abort) begin
                            r_state  <= CLR;
                            r_busy   <= 1'b1;
                            r_thr    <= bus.thresh;
                            r_thr_en <= bus.thresh_en;
                        end
                    end
                    CLR: begin
                        r_sum   <= '0;
                        r_addr  <= '0;
                        r_hit   <= 1'b0;
                        r_rd_en <= 1'b1;
                        r_state <= RUN;
                    end
                    RUN: begin
                        if ((r_addr == c_last) || w_hit) begin
                            r_rd_en <= 1'b0;
                            r_hit   <= w_hit;
                            r_state <= DRAIN;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                    DRAIN: begin
                        // Last issued word is on the bus now; fold it in.
                        r_sad   <= r_vld ? w_sum_next : r_sum;
                        r_early <= r_hit;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                    DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_rd_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_addr;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.sad     = r_sad;
    assign bus.early   = r_early;

endmodule : sad_engine
`default_nettype wire

// File: tb/tb_sad_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sad_engine
//  Description : Directed self-checking bench for sad_engine (N=256, LANES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_engine;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    sad_if #(.PIX_W(8), .N(256), .LANES(4)) bus ();

    sad_engine #(.PIX_W(8), .N(256), .LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous-read pixel memories, one-cycle latency.
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] r_a_q;
    logic [31:0] r_b_q;

    always @(posedge clk) begin
        if (bus.rd_en) begin
            r_a_q <= mem_a[bus.rd_addr];
            r_b_q <= mem_b[bus.rd_addr];
        end
    end

    assign bus.a_data = r_a_q;
    assign bus.b_data = r_b_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every pixel of A = pa, every pixel of B = pb.
    task automatic fill_const(input logic [7:0] pa, input logic [7:0] pb);
        for (int w = 0; w < 64; w++) begin
            mem_a[w] = {4{pa}};
            mem_b[w] = {4{pb}};
        end
    endtask

    // Pixel p: even -> A=FF/B=00, odd -> A=00/B=FF. Every pixel differs by 255.
    task automatic fill_alt();
        for (int w = 0; w < 64; w++) begin
            for (int k = 0; k < 4; k++) begin
                mem_a[w][k*8 +: 8] = ((w*4 + k) % 2 == 0) ? 8'hFF : 8'h00;
                mem_b[w][k*8 +: 8] = ((w*4 + k) % 2 == 0) ? 8'h00 : 8'hFF;
            end
        end
    endtask

    // Pulse go for one edge; returns in cycle 1 (CLR).
    task automatic start_go();
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    // Advance until done is seen, counting cycles from 'start'; bounded.
    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (bus.done !== 1'b1 && cyc < start + 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int seen;

    initial begin
        n_checks      = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.go        = 1'b0;
        bus.abort     = 1'b0;
        bus.thresh_en = 1'b0;
        bus.thresh    = '0;
        fill_const(8'h10, 8'h0C);
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_rd_en",   32'(bus.rd_en),   0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 0);
        chk("rst_busy",    32'(bus.busy),    0);
        chk("rst_done",    32'(bus.done),    0);
        chk("rst_sad",     32'(bus.sad),     0);
        chk("rst_early",   32'(bus.early),   0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: |0x10-0x0C| = 4 per pixel -> 1024, done at cycle 67
        start_go();
        chk("t1_busy_c1",  32'(bus.busy),  1);
        chk("t1_rden_c1",  32'(bus.rd_en), 0);
        @(negedge clk);
        chk("t1_rden_c2",  32'(bus.rd_en), 1);
        chk("t1_addr_c2",  32'(bus.rd_addr), 0);
        wait_done(2, cyc);
        chk("t1_done_cyc", 32'(cyc), 67);
        chk("t1_sad",      32'(bus.sad), 1024);
        chk("t1_early",    32'(bus.early), 0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(bus.done), 0);
        chk("t1_busy_idle",  32'(bus.busy), 0);
        chk("t1_sad_held",   32'(bus.sad), 1024);

        // T2: all pixels differ by 255 -> 65280
        fill_alt();
        start_go();
        wait_done(1, cyc);
        chk("t2_done_cyc", 32'(cyc), 67);
        chk("t2_sad",      32'(bus.sad), 65280);
        chk("t2_early",    32'(bus.early), 0);
        @(negedge clk);

        // T3: 1020 per word; sum>=2000 seen in cycle 5 -> words 0..3 issued
        bus.thresh_en = 1'b1;
        bus.thresh    = 17'd2000;
        start_go();
        repeat (5) @(negedge clk);
        chk("t3_rden_c6",  32'(bus.rd_en), 0);
        chk("t3_busy_c6",  32'(bus.busy),  1);
        wait_done(6, cyc);
        chk("t3_done_cyc", 32'(cyc), 7);
        chk("t3_sad",      32'(bus.sad), 4080);
        chk("t3_early",    32'(bus.early), 1);
        @(negedge clk);

        // T4: threshold exactly equal to 2*1020 must trigger at the same point
        bus.thresh = 17'd2040;
        start_go();
        wait_done(1, cyc);
        chk("t4_done_cyc", 32'(cyc), 7);
        chk("t4_sad",      32'(bus.sad), 4080);
        chk("t4_early",    32'(bus.early), 1);
        @(negedge clk);
        bus.thresh_en = 1'b0;

        // T5: abort at rd_addr=10
        start_go();
        cyc = 1;
        while (!(bus.rd_en === 1'b1 && bus.rd_addr === 6'd10) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5_abort_point", 32'(cyc), 12);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t5_busy_after", 32'(bus.busy),  0);
        chk("t5_rden_after", 32'(bus.rd_en), 0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        chk("t5_no_done",  32'(seen), 0);
        chk("t5_sad_kept", 32'(bus.sad), 4080);
        chk("t5_early_kept", 32'(bus.early), 1);
        fill_const(8'h10, 8'h0C);
        start_go();
        wait_done(1, cyc);
        chk("t5_rerun_cyc", 32'(cyc), 67);
        chk("t5_rerun_sad", 32'(bus.sad), 1024);
        chk("t5_rerun_early", 32'(bus.early), 0);
        @(negedge clk);

        // T6: go and abort together in IDLE -> stay IDLE
        bus.go    = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.go    = 1'b0;
        bus.abort = 1'b0;
        chk("t6_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("t6_busy_later", 32'(bus.busy), 0);

        // T7: go held high -> one run per IDLE visit, next run after done
        fill_alt();
        bus.go = 1'b1;
        @(negedge clk);
        wait_done(1, cyc);
        chk("t7_done1_cyc", 32'(cyc), 67);
        @(negedge clk);
        chk("t7_idle_gap", 32'(bus.busy), 0);
        @(negedge clk);
        chk("t7_rerun_busy", 32'(bus.busy), 1);
        bus.go = 1'b0;
        wait_done(69, cyc);
        chk("t7_done2_cyc", 32'(cyc), 135);
        chk("t7_sad", 32'(bus.sad), 65280);
        @(negedge clk);

        // T8: go pulse during RUN is ignored
        fill_const(8'h10, 8'h0C);
        start_go();
        repeat (9) @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        wait_done(11, cyc);
        chk("t8_done_cyc", 32'(cyc), 67);
        chk("t8_sad", 32'(bus.sad), 1024);
        @(negedge clk);
        @(negedge clk);
        chk("t8_no_second_run", 32'(bus.busy), 0);

        // T9: asynchronous reset pulse during DRAIN
        fill_alt();
        start_go();
        repeat (65) @(negedge clk);
        chk("t9_pre_busy", 32'(bus.busy), 1);
        chk("t9_pre_rden", 32'(bus.rd_en), 0);
        #2 rst = 1'b1;
        #1;
        chk("t9_busy",  32'(bus.busy),  0);
        chk("t9_done",  32'(bus.done),  0);
        chk("t9_sad",   32'(bus.sad),   0);
        chk("t9_early", 32'(bus.early), 0);
        chk("t9_rden",  32'(bus.rd_en), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        chk("t9_no_done", 32'(seen), 0);
        chk("t9_idle",    32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule : tb_sad_engine
`default_nettype wire
